// File: rtl/log_lut_arbiter.sv
// Round-robin arbiter sharing one combinational log LUT between NUM_REQ lanes.
// Two stages: S1 holds the registered LUT address, S2 holds the back-pressurable response.
module log_lut_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         lut_addr,
    input  logic [DATA_W-1:0]         lut_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshakes on both sides are valid & ready in the same cycle; a lane's
    // request may be withdrawn before it is granted, a response is held until taken.
    logic               s1_vld;
    logic [PTR_W-1:0]   s1_id;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_id;
    logic [PTR_W-1:0]   rr_next;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] s1_onehot;
    logic [ADDR_W-1:0]  gnt_addr;
    logic               gnt_found;
    logic               s2_fire;
    logic               adv2;
    logic               acc1;
    logic               hs;

    assign s2_fire = |(rsp_valid & rsp_ready);
    assign adv2    = s1_vld & (~|rsp_valid | s2_fire);
    assign acc1    = ~s1_vld | adv2;

    // First pending lane at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_found = 1'b1;
                gnt_id    = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
                gnt[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

    assign req_ready = (acc1 && resetn) ? gnt : '0;
    assign hs        = |(req_valid & req_ready);
    assign gnt_addr  = req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
    assign rr_next   = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign s1_onehot = NUM_REQ'(1) << s1_id;
    assign busy      = s1_vld | (|rsp_valid);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_vld    <= 1'b0;
            s1_id     <= '0;
            lut_addr  <= '0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            // A new grant only happens when S1 is free or moving on, so it may overwrite S1.
            if (hs) begin
                s1_vld   <= 1'b1;
                s1_id    <= gnt_id;
                lut_addr <= gnt_addr;
                rr_ptr   <= rr_next;
            end else if (adv2) begin
                s1_vld <= 1'b0;
            end

            if (adv2) begin
                rsp_valid <= s1_onehot;
                rsp_data  <= lut_data;
            end else if (s2_fire) begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_log_lut_arbiter.sv
// Directed bench for log_lut_arbiter: arbitration order, latency, stall, reset and withdraw cases.
module tb_log_lut_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_ready;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;
    logic [19:0] exp_q[$];

    log_lut_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lut_fn(input logic [7:0] a);
        case (a)
            8'h00:   return 16'h0000;
            8'h01:   return 16'h1BFC;
            8'h02:   return 16'h1FF8;
            8'h80:   return 16'h367D;
            default: return {a, a ^ 8'hA5};
        endcase
    endfunction

    always_comb lut_data = lut_fn(lut_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int lane, input logic [7:0] a);
        req_addr[lane*8 +: 8] = a;
    endtask

    task automatic push_exp(input int lane);
        logic [3:0] oh;
        oh = 4'b0001 << lane;
        exp_q.push_back({oh, lut_fn(req_addr[lane*8 +: 8])});
    endtask

    // Response scoreboard: every accepted response must match the oldest expected one.
    always @(negedge clk) begin
        if ((rsp_valid & rsp_ready) != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check_eq("rsp_unexpected", {12'h0, rsp_valid, rsp_data}, 32'h0);
            end else begin
                check_eq("rsp_order", {12'h0, rsp_valid, rsp_data}, {12'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin : main
        int g3_lane[8];
        logic [3:0] g3_oh[8];
        resetn    = 1'b0;
        req_valid = 4'hF;
        req_addr  = '0;
        rsp_ready = 4'hF;

        // Reset state
        #12;
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_lut_addr", lut_addr, 0);
        req_valid = 4'h0;
        step();
        resetn = 1'b1;

        // Test 1: single lookup latency
        step();
        set_addr(2, 8'h01);
        req_valid = 4'b0100;
        @(negedge clk);
        check_eq("t1_grant", req_ready, 4'b0100);
        check_eq("t1_busy_idle", busy, 0);
        push_exp(2);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("t1_lut_addr", lut_addr, 8'h01);
        check_eq("t1_busy_s1", busy, 1);
        check_eq("t1_rsp_early", rsp_valid, 0);
        @(negedge clk);
        check_eq("t1_rsp_valid", rsp_valid, 4'b0100);
        check_eq("t1_rsp_data", rsp_data, 16'h1BFC);
        @(negedge clk);
        check_eq("t1_busy_end", busy, 0);
        check_eq("t1_rsp_end", rsp_valid, 0);

        // Test 2: full-rate round robin from rr_ptr=0
        step();
        resetn = 1'b0;
        exp_q.delete();
        #2;
        resetn = 1'b1;
        step();
        set_addr(0, 8'h00); set_addr(1, 8'h02); set_addr(2, 8'h80); set_addr(3, 8'h01);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq($sformatf("t2_grant%0d", k), req_ready, 4'b0001 << (k % 4));
            if (k >= 2) check_eq($sformatf("t2_rsp%0d", k), rsp_valid, 4'b0001 << ((k - 2) % 4));
            push_exp(k % 4);
            step();
        end
        req_valid = 4'h0;
        repeat (3) step();
        check_eq("t2_drained", exp_q.size(), 0);

        // Test 3: lane 1 stalls its response for three cycles
        g3_lane = '{0, 1, 2, -1, -1, -1, 3, 0};
        g3_oh   = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            rsp_ready = (c < 6) ? 4'b1101 : 4'b1111;
            @(negedge clk);
            check_eq($sformatf("t3_grant%0d", c), req_ready, g3_oh[c]);
            if (c >= 3 && c <= 5) begin
                check_eq($sformatf("t3_hold_v%0d", c), rsp_valid, 4'b0010);
                check_eq($sformatf("t3_hold_d%0d", c), rsp_data, 16'h1FF8);
            end
            if (g3_lane[c] >= 0) push_exp(g3_lane[c]);
            step();
        end
        req_valid = 4'h0;
        repeat (4) step();
        check_eq("t3_drained", exp_q.size(), 0);

        // Test 4: bring rr_ptr to 2, then lanes 1 and 3 compete
        req_valid = 4'b0010;
        @(negedge clk);
        check_eq("t4_pre", req_ready, 4'b0010);
        push_exp(1);
        step();
        req_valid = 4'b1010;
        @(negedge clk);
        check_eq("t4_first", req_ready, 4'b1000);
        push_exp(3);
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        check_eq("t4_second", req_ready, 4'b0010);
        push_exp(1);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("t4_rr_ptr", dut.rr_ptr, 2);
        repeat (3) step();
        check_eq("t4_drained", exp_q.size(), 0);

        // Test 5: asynchronous reset with both stages full
        rsp_ready = 4'b0000;
        set_addr(0, 8'h80);
        req_valid = 4'b0001;
        @(negedge clk);
        check_eq("t5_g0", req_ready, 4'b0001);
        step();
        @(negedge clk);
        check_eq("t5_g1", req_ready, 4'b0001);
        step();
        @(negedge clk);
        check_eq("t5_full_ready", req_ready, 0);
        check_eq("t5_full_rsp", rsp_valid, 4'b0001);
        check_eq("t5_full_addr", lut_addr, 8'h80);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check_eq("t5_rst_rsp_valid", rsp_valid, 0);
        check_eq("t5_rst_rsp_data", rsp_data, 0);
        check_eq("t5_rst_lut_addr", lut_addr, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_ready", req_ready, 0);
        req_valid = 4'b0000;
        step();
        resetn = 1'b1;
        rsp_ready = 4'hF;
        req_valid = 4'b0101;
        @(negedge clk);
        check_eq("t5_after_g0", req_ready, 4'b0001);
        push_exp(0);
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        check_eq("t5_after_g2", req_ready, 4'b0100);
        push_exp(2);
        step();
        req_valid = 4'b0000;
        repeat (3) step();
        check_eq("t5_drained", exp_q.size(), 0);

        // Test 6: lane 0 withdraws its request during a stall
        rsp_ready = 4'b0000;
        set_addr(3, 8'h02);
        req_valid = 4'b1000;
        @(negedge clk);
        check_eq("t6_g3a", req_ready, 4'b1000);
        push_exp(3);
        step();
        @(negedge clk);
        check_eq("t6_g3b", req_ready, 4'b1000);
        push_exp(3);
        step();
        req_valid = 4'b0001;
        @(negedge clk);
        check_eq("t6_stall_ready", req_ready, 0);
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("t6_stall_rsp", rsp_valid, 4'b1000);
        step();
        rsp_ready = 4'hF;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("t6_no_lane0_%0d", c), rsp_valid & 4'b0001, 0);
            check_eq($sformatf("t6_no_grant_%0d", c), req_ready, 0);
            step();
        end
        check_eq("t6_drained", exp_q.size(), 0);
        check_eq("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
